rf_blackwidow_wb_queue: RTL and testbench
=========================================

# rf_blackwidow_wb_queue

Writeback stage directly downstream of the BlackWidow ALU. It accepts one ALU result per cycle with a valid/ready handshake and buffers it in a small in-order queue. It drains one entry per cycle into the register-file write port and exposes two forwarding lookup ports so the operand stage can pick up results that are not yet written.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, 2..16
- RW, 6: register-number width
- CW, 32: retire-counter width

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- alu_v_i  in  1  ALU result valid
- alu_rdy_o  out  1  queue can accept; equals (count < DEPTH)
- alu_res_i  in  80  ALU result (Value)
- alu_rt_i  in  RW  destination register
- alu_tid_i  in  8  thread id
- rf_stall_i  in  1  register file cannot take a write this cycle
- rf_wr_o  out  1  register-file write enable, one-cycle pulse per entry
- rf_wa_o  out  RW  write address
- rf_wd_o  out  80  write data
- rf_tid_o  out  8  thread id of the write
- fwd_ra_i, fwd_rb_i  in  RW  forwarding lookup registers
- fwd_ha_o, fwd_hb_o  out  1  lookup hit
- fwd_va_o, fwd_vb_o  out  80  forwarded value; 0 when no hit
- ret_cnt_o  out  CW  count of register writes issued

## Operation
- The queue is a circular buffer with a write pointer, a read pointer and count (0..DEPTH). Both pointers wrap modulo DEPTH.
- Accept happens when alu_v_i && alu_rdy_o.
  - If alu_rt_i == 0, the result is accepted and discarded: the queue is unchanged and no write occurs.
  - Otherwise {res, rt, tid} is pushed at the write pointer.
- Pop happens when count != 0 && !rf_stall_i. The head entry is loaded into the output register: rf_wr_o=1, rf_wa_o, rf_wd_o and rf_tid_o are set next cycle, and ret_cnt_o increments.
  - When no entry is popped, rf_wr_o=0 next cycle. rf_wa_o, rf_wd_o and rf_tid_o hold their values.
- Push and pop in the same cycle leave count unchanged.
- At full, alu_rdy_o=0 even if a pop occurs that cycle. There is no pass-through at full.
- Forwarding is combinational. For each lookup, candidates are the valid queue entries plus the output register while rf_wr_o=1.
  - The youngest matching candidate wins: queue newest to oldest, then the output register.
  - A lookup of register 0 never hits.
  - An entry being accepted in the current cycle is not visible.
- ret_cnt_o wraps at 2^CW.
- Reset values: count, pointers, rf_wr_o, rf_wa_o, rf_wd_o, rf_tid_o, ret_cnt_o and all forwarding outputs are 0, and alu_rdy_o=1 in the first cycle after reset.
- Asserting rst_i mid-operation discards all queued entries, and no write pulse is issued in the cycle after reset.

## Timing
- Without bypass, a result accepted in cycle N is at the head in N+1. With no stall, rf_wr_o=1 for it in N+2.
- With bypass (see Configuration), the same result produces rf_wr_o=1 in N+1.
- Throughput is one accept and one write per cycle, sustained.
- alu_rdy_o depends only on registered count. There is no combinational path from alu_v_i or rf_stall_i to alu_rdy_o.
- Forwarding has a combinational path from fwd_r*_i to fwd_h*/fwd_v*_o only.

## Configuration
- BW_WB_BYPASS_EN defined: when count == 0, !rf_stall_i and a nonzero-rt accept occurs, the entry goes directly to the output register and skips the queue. Latency is 1. Queue state is unchanged.
- BW_WB_BYPASS_EN undefined: every accepted entry passes through the queue. Latency is 2.
- All other behaviour is identical with and without the macro.

## Test plan
- Single result: res=80'h1234, rt=5 accepted in cycle 10, no stall. Required: rf_wr_o=1, rf_wa_o=5, rf_wd_o=80'h1234 in cycle 12 (cycle 11 with BW_WB_BYPASS_EN), and ret_cnt_o=1.
- Backpressure: hold rf_stall_i=1 and push rt=1..5. Required: alu_rdy_o drops to 0 after the 4th accept, and the 5th is held. Release the stall: writes rt=1,2,3,4,5 occur on consecutive cycles in order.
- Register zero: push rt=0 with res=80'hFF. Required: no rf_wr_o pulse, ret_cnt_o unchanged, and a fwd_ra_i=0 lookup misses.
- Forwarding priority: under stall, push rt=7 res=1, then rt=7 res=2. Required: fwd_ra_i=7 gives fwd_ha_o=1, fwd_va_o=2, and fwd_rb_i=8 gives fwd_hb_o=0, fwd_vb_o=0.
- Reset mid-operation: with 3 entries queued, assert rst_i for 1 cycle. Required: no further rf_wr_o pulses, ret_cnt_o=0, alu_rdy_o=1, and all forwarding lookups miss.
- Full with simultaneous pop: at count=4, release the stall while alu_v_i=1. Required: no accept that cycle, count becomes 3, and the accept occurs the following cycle.

Source files
------------

// File: rtl/rf_blackwidow_wb_queue.sv
// rf_blackwidow_wb_queue
// Writeback stage behind the BlackWidow ALU. ALU results are buffered in a
// small in-order circular queue. The queue drains one entry per cycle into a
// registered register-file write port. Two combinational forwarding lookups
// let the operand stage see results that are not yet written.
//
// Handshake: a result is taken on any cycle where alu_v_i && alu_rdy_o.
// alu_rdy_o depends only on the registered count. It stays low while the
// queue is full, even in a cycle where the head drains, so a full queue
// never passes a result straight through.
//
// Optional feature macro: BW_WB_BYPASS_EN. When it is defined, a result that
// arrives at an empty, unstalled queue skips the queue and goes directly to
// the output register, giving a latency of 1 instead of 2.
module rf_blackwidow_wb_queue #(
   parameter int DEPTH = 4,
   parameter int RW    = 6,
   parameter int CW    = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          alu_v_i,
   output logic          alu_rdy_o,
   input  logic [79:0]   alu_res_i,
   input  logic [RW-1:0] alu_rt_i,
   input  logic [7:0]    alu_tid_i,
   input  logic          rf_stall_i,
   output logic          rf_wr_o,
   output logic [RW-1:0] rf_wa_o,
   output logic [79:0]   rf_wd_o,
   output logic [7:0]    rf_tid_o,
   input  logic [RW-1:0] fwd_ra_i,
   input  logic [RW-1:0] fwd_rb_i,
   output logic          fwd_ha_o,
   output logic          fwd_hb_o,
   output logic [79:0]   fwd_va_o,
   output logic [79:0]   fwd_vb_o,
   output logic [CW-1:0] ret_cnt_o
);

   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = AW + 1;

   // Queue storage; only entries inside [rd_ptr, rd_ptr + count) are meaningful
   logic [79:0]   res_mem [DEPTH];
   logic [RW-1:0] rt_mem  [DEPTH];
   logic [7:0]    tid_mem [DEPTH];

   logic [AW-1:0]   wp_q, wp_d;
   logic [AW-1:0]   rp_q, rp_d;
   logic [CNTW-1:0] cnt_q, cnt_d;

   logic          wr_q, wr_d;
   logic [RW-1:0] wa_q, wa_d;
   logic [79:0]   wd_q, wd_d;
   logic [7:0]    tid_q, tid_d;
   logic [CW-1:0] ret_q, ret_d;

   logic accept;
   logic keep;
   logic pop;
   logic byp;
   logic enq;

   assign alu_rdy_o = (cnt_q < CNTW'(DEPTH));
   assign accept    = alu_v_i && alu_rdy_o;
   // Results targeting register 0 are acknowledged but dropped
   assign keep      = accept && (alu_rt_i != '0);
   assign pop       = (cnt_q != '0) && !rf_stall_i;

`ifdef BW_WB_BYPASS_EN
   // Empty and unstalled: the incoming result can be written next cycle directly
   assign byp = keep && (cnt_q == '0) && !rf_stall_i;
`else
   assign byp = 1'b0;
`endif

   assign enq = keep && !byp;

   // Next-state for pointers, count and the register-file output register
   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      wr_d  = 1'b0;
      wa_d  = wa_q;
      wd_d  = wd_q;
      tid_d = tid_q;
      ret_d = ret_q;

      if (enq) begin
         wp_d = wp_q + AW'(1);
      end
      if (pop) begin
         rp_d = rp_q + AW'(1);
      end

      if (enq && !pop) begin
         cnt_d = cnt_q + CNTW'(1);
      end else if (!enq && pop) begin
         cnt_d = cnt_q - CNTW'(1);
      end

      // Pop and bypass are mutually exclusive: bypass needs an empty queue
      if (pop) begin
         wr_d  = 1'b1;
         wa_d  = rt_mem[rp_q];
         wd_d  = res_mem[rp_q];
         tid_d = tid_mem[rp_q];
         ret_d = ret_q + CW'(1);
      end else if (byp) begin
         wr_d  = 1'b1;
         wa_d  = alu_rt_i;
         wd_d  = alu_res_i;
         tid_d = alu_tid_i;
         ret_d = ret_q + CW'(1);
      end
   end

   // Control and output registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         wr_q  <= 1'b0;
         wa_q  <= '0;
         wd_q  <= '0;
         tid_q <= '0;
         ret_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
         wr_q  <= wr_d;
         wa_q  <= wa_d;
         wd_q  <= wd_d;
         tid_q <= tid_d;
         ret_q <= ret_d;
      end
   end

   // Queue payload write; contents need no reset because count gates validity
   always_ff @(posedge clk_i) begin
      if (!rst_i && enq) begin
         res_mem[wp_q] <= alu_res_i;
         rt_mem[wp_q]  <= alu_rt_i;
         tid_mem[wp_q] <= alu_tid_i;
      end
   end

   assign rf_wr_o   = wr_q;
   assign rf_wa_o   = wa_q;
   assign rf_wd_o   = wd_q;
   assign rf_tid_o  = tid_q;
   assign ret_cnt_o = ret_q;

   // Youngest match wins: start from the output register, then walk the
   // queue oldest to newest so that each later match overrides the earlier one
   function automatic logic [80:0] lookup(input logic [RW-1:0] r);
      logic          hit;
      logic [79:0]   val;
      logic [AW-1:0] idx;
      hit = 1'b0;
      val = '0;
      idx = '0;
      if (r != '0) begin
         if (wr_q && (wa_q == r)) begin
            hit = 1'b1;
            val = wd_q;
         end
         for (int i = 0; i < DEPTH; i++) begin
            idx = rp_q + AW'(i);
            if ((CNTW'(i) < cnt_q) && (rt_mem[idx] == r)) begin
               hit = 1'b1;
               val = res_mem[idx];
            end
         end
      end
      return {hit, val};
   endfunction

   // Combinational forwarding for both lookup ports
   always_comb begin
      {fwd_ha_o, fwd_va_o} = lookup(fwd_ra_i);
      {fwd_hb_o, fwd_vb_o} = lookup(fwd_rb_i);
   end

endmodule

// File: tb/tb_rf_blackwidow_wb_queue.sv
// Bench for rf_blackwidow_wb_queue: a fixed vector table, hand-written
// sequences for latency, forwarding priority and reset, then random traffic
// checked against a queue-based reference model.
module tb_rf_blackwidow_wb_queue;

   localparam int DEPTH = 4;
   localparam int RW    = 6;
   localparam int CW    = 32;

   // Clock/reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          alu_v;
   logic          alu_rdy;
   logic [79:0]   alu_res;
   logic [RW-1:0] alu_rt;
   logic [7:0]    alu_tid;
   logic          rf_stall;
   logic          rf_wr;
   logic [RW-1:0] rf_wa;
   logic [79:0]   rf_wd;
   logic [7:0]    rf_tid;
   logic [RW-1:0] fwd_ra, fwd_rb;
   logic          fwd_ha, fwd_hb;
   logic [79:0]   fwd_va, fwd_vb;
   logic [CW-1:0] ret_cnt;

   rf_blackwidow_wb_queue #(.DEPTH(DEPTH), .RW(RW), .CW(CW)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .alu_v_i    (alu_v),
      .alu_rdy_o  (alu_rdy),
      .alu_res_i  (alu_res),
      .alu_rt_i   (alu_rt),
      .alu_tid_i  (alu_tid),
      .rf_stall_i (rf_stall),
      .rf_wr_o    (rf_wr),
      .rf_wa_o    (rf_wa),
      .rf_wd_o    (rf_wd),
      .rf_tid_o   (rf_tid),
      .fwd_ra_i   (fwd_ra),
      .fwd_rb_i   (fwd_rb),
      .fwd_ha_o   (fwd_ha),
      .fwd_hb_o   (fwd_hb),
      .fwd_va_o   (fwd_va),
      .fwd_vb_o   (fwd_vb),
      .ret_cnt_o  (ret_cnt)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Reference model: an ordered list of pending results plus the write port
   typedef struct {
      logic [79:0]   res;
      logic [RW-1:0] rt;
      logic [7:0]    tid;
   } ent_t;

   ent_t          mq[$];
   logic          m_wr;
   logic [RW-1:0] m_wa;
   logic [79:0]   m_wd;
   logic [7:0]    m_tid;
   logic [CW-1:0] m_ret;

   task automatic model_clear();
      mq.delete();
      m_wr  = 1'b0;
      m_wa  = '0;
      m_wd  = '0;
      m_tid = '0;
      m_ret = '0;
   endtask

   // Apply one clock edge worth of behaviour using the inputs held at the edge
   task automatic model_edge();
      ent_t e;
      bit   rdy, keep, do_pop, do_byp;
      if (rst) begin
         model_clear();
      end else begin
         rdy    = (mq.size() < DEPTH);
         keep   = alu_v && rdy && (alu_rt != '0);
         do_pop = (mq.size() != 0) && !rf_stall;
`ifdef BW_WB_BYPASS_EN
         do_byp = keep && (mq.size() == 0) && !rf_stall;
`else
         do_byp = 1'b0;
`endif
         e.res = alu_res;
         e.rt  = alu_rt;
         e.tid = alu_tid;
         m_wr  = 1'b0;
         if (do_pop) begin
            ent_t h;
            h = mq.pop_front();
            m_wr = 1'b1; m_wa = h.rt; m_wd = h.res; m_tid = h.tid;
            m_ret = m_ret + 1;
         end else if (do_byp) begin
            m_wr = 1'b1; m_wa = e.rt; m_wd = e.res; m_tid = e.tid;
            m_ret = m_ret + 1;
         end
         if (keep && !do_byp) mq.push_back(e);
      end
   endtask

   // Search newest pending result first, then the result being written
   task automatic model_fwd(input logic [RW-1:0] r, output logic h, output logic [79:0] v);
      h = 1'b0;
      v = '0;
      if (r != '0) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!h && mq[i].rt == r) begin
               h = 1'b1;
               v = mq[i].res;
            end
         end
         if (!h && m_wr && m_wa == r) begin
            h = 1'b1;
            v = m_wd;
         end
      end
   endtask

   task automatic check_model();
      logic        h;
      logic [79:0] v;
      chk("rdy", 80'(alu_rdy), 80'(mq.size() < DEPTH));
      chk("wr", 80'(rf_wr), 80'(m_wr));
      chk("wa", 80'(rf_wa), 80'(m_wa));
      chk("wd", rf_wd, m_wd);
      chk("tid", 80'(rf_tid), 80'(m_tid));
      chk("ret", 80'(ret_cnt), 80'(m_ret));
      model_fwd(fwd_ra, h, v);
      chk("fwd_ha", 80'(fwd_ha), 80'(h));
      chk("fwd_va", fwd_va, v);
      model_fwd(fwd_rb, h, v);
      chk("fwd_hb", 80'(fwd_hb), 80'(h));
      chk("fwd_vb", fwd_vb, v);
   endtask

   // Driver tasks
   task automatic drive(input logic v, input logic [79:0] res, input logic [RW-1:0] rt,
                        input logic st, input logic [RW-1:0] ra, input logic [RW-1:0] rb);
      alu_v    = v;
      alu_res  = res;
      alu_rt   = rt;
      alu_tid  = 8'h10 | {2'b00, rt};
      rf_stall = st;
      fwd_ra   = ra;
      fwd_rb   = rb;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Vector table
   typedef struct {
      logic          v;
      logic [79:0]   res;
      logic [RW-1:0] rt;
      logic          st;
      logic [RW-1:0] ra, rb;
      logic          e_rdy, e_wr;
      logic [RW-1:0] e_wa;
      logic [79:0]   e_wd;
      logic [CW-1:0] e_ret;
      logic          e_ha;
      logic [79:0]   e_va;
      logic          e_hb;
      logic [79:0]   e_vb;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(input logic v, input logic [79:0] res, input logic [RW-1:0] rt,
                               input logic st, input logic [RW-1:0] ra, input logic [RW-1:0] rb,
                               input logic er, input logic ew, input logic [RW-1:0] ewa,
                               input logic [79:0] ewd, input logic [CW-1:0] eret,
                               input logic eha, input logic [79:0] eva,
                               input logic ehb, input logic [79:0] evb);
      vec_t t;
      t.v = v; t.res = res; t.rt = rt; t.st = st; t.ra = ra; t.rb = rb;
      t.e_rdy = er; t.e_wr = ew; t.e_wa = ewa; t.e_wd = ewd; t.e_ret = eret;
      t.e_ha = eha; t.e_va = eva; t.e_hb = ehb; t.e_vb = evb;
      return t;
   endfunction

   initial begin
      logic [7:0]  etid;
      logic [95:0] r96;

      // Fill after reset: stall while filling, full-with-pop, drain, register 0
      tbl[0]  = mk(1'b0, 80'h0,  6'd0, 1'b1, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0, 80'h0,  32'd0, 1'b0, 80'h0,  1'b0, 80'h0);
      tbl[1]  = mk(1'b1, 80'h11, 6'd1, 1'b1, 6'd1, 6'd0, 1'b1, 1'b0, 6'd0, 80'h0,  32'd0, 1'b0, 80'h0,  1'b0, 80'h0);
      tbl[2]  = mk(1'b1, 80'h22, 6'd2, 1'b1, 6'd1, 6'd8, 1'b1, 1'b0, 6'd0, 80'h0,  32'd0, 1'b1, 80'h11, 1'b0, 80'h0);
      tbl[3]  = mk(1'b1, 80'h33, 6'd3, 1'b1, 6'd2, 6'd0, 1'b1, 1'b0, 6'd0, 80'h0,  32'd0, 1'b1, 80'h22, 1'b0, 80'h0);
      tbl[4]  = mk(1'b1, 80'h44, 6'd4, 1'b1, 6'd3, 6'd1, 1'b1, 1'b0, 6'd0, 80'h0,  32'd0, 1'b1, 80'h33, 1'b1, 80'h11);
      tbl[5]  = mk(1'b1, 80'h55, 6'd5, 1'b1, 6'd4, 6'd0, 1'b0, 1'b0, 6'd0, 80'h0,  32'd0, 1'b1, 80'h44, 1'b0, 80'h0);
      tbl[6]  = mk(1'b1, 80'h55, 6'd5, 1'b0, 6'd5, 6'd0, 1'b0, 1'b0, 6'd0, 80'h0,  32'd0, 1'b0, 80'h0,  1'b0, 80'h0);
      tbl[7]  = mk(1'b1, 80'h55, 6'd5, 1'b0, 6'd1, 6'd0, 1'b1, 1'b1, 6'd1, 80'h11, 32'd1, 1'b1, 80'h11, 1'b0, 80'h0);
      tbl[8]  = mk(1'b0, 80'h0,  6'd0, 1'b0, 6'd5, 6'd0, 1'b1, 1'b1, 6'd2, 80'h22, 32'd2, 1'b1, 80'h55, 1'b0, 80'h0);
      tbl[9]  = mk(1'b0, 80'h0,  6'd0, 1'b0, 6'd2, 6'd3, 1'b1, 1'b1, 6'd3, 80'h33, 32'd3, 1'b0, 80'h0,  1'b1, 80'h33);
      tbl[10] = mk(1'b0, 80'h0,  6'd0, 1'b0, 6'd4, 6'd0, 1'b1, 1'b1, 6'd4, 80'h44, 32'd4, 1'b1, 80'h44, 1'b0, 80'h0);
      tbl[11] = mk(1'b0, 80'h0,  6'd0, 1'b0, 6'd5, 6'd0, 1'b1, 1'b1, 6'd5, 80'h55, 32'd5, 1'b1, 80'h55, 1'b0, 80'h0);
      tbl[12] = mk(1'b0, 80'h0,  6'd0, 1'b0, 6'd5, 6'd0, 1'b1, 1'b0, 6'd5, 80'h55, 32'd5, 1'b0, 80'h0,  1'b0, 80'h0);
      tbl[13] = mk(1'b1, 80'hFF, 6'd0, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd5, 80'h55, 32'd5, 1'b0, 80'h0,  1'b0, 80'h0);
      tbl[14] = mk(1'b0, 80'h0,  6'd0, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd5, 80'h55, 32'd5, 1'b0, 80'h0,  1'b0, 80'h0);
      tbl[15] = mk(1'b0, 80'h0,  6'd0, 1'b0, 6'd5, 6'd0, 1'b1, 1'b0, 6'd5, 80'h55, 32'd5, 1'b0, 80'h0,  1'b0, 80'h0);

      model_clear();
      rst = 1'b1;
      drive(1'b0, 80'h0, 6'd0, 1'b0, 6'd0, 6'd0);
      cyc();
      cyc();
      rst = 1'b0;

      // Table phase
      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].v, tbl[i].res, tbl[i].rt, tbl[i].st, tbl[i].ra, tbl[i].rb);
         #4;
         etid = (tbl[i].e_wa == '0) ? 8'h00 : (8'h10 | {2'b00, tbl[i].e_wa});
         chk("t_rdy", 80'(alu_rdy), 80'(tbl[i].e_rdy));
         chk("t_wr", 80'(rf_wr), 80'(tbl[i].e_wr));
         chk("t_wa", 80'(rf_wa), 80'(tbl[i].e_wa));
         chk("t_wd", rf_wd, tbl[i].e_wd);
         chk("t_tid", 80'(rf_tid), 80'(etid));
         chk("t_ret", 80'(ret_cnt), 80'(tbl[i].e_ret));
         chk("t_ha", 80'(fwd_ha), 80'(tbl[i].e_ha));
         chk("t_va", fwd_va, tbl[i].e_va);
         chk("t_hb", 80'(fwd_hb), 80'(tbl[i].e_hb));
         chk("t_vb", fwd_vb, tbl[i].e_vb);
         cyc();
      end

      // Single result latency
      rst = 1'b1;
      drive(1'b0, 80'h0, 6'd0, 1'b0, 6'd0, 6'd0);
      cyc();
      rst = 1'b0;
      drive(1'b1, 80'h1234, 6'd5, 1'b0, 6'd0, 6'd0);
      #4;
      chk("s_rdy", 80'(alu_rdy), 80'(1));
      chk("s_ret0", 80'(ret_cnt), 80'(0));
      cyc();
      drive(1'b0, 80'h0, 6'd0, 1'b0, 6'd0, 6'd0);
      #4;
`ifdef BW_WB_BYPASS_EN
      chk("s_wr_n1", 80'(rf_wr), 80'(1));
      chk("s_wa_n1", 80'(rf_wa), 80'(5));
      chk("s_wd_n1", rf_wd, 80'h1234);
      chk("s_ret_n1", 80'(ret_cnt), 80'(1));
`else
      chk("s_wr_n1", 80'(rf_wr), 80'(0));
      chk("s_ret_n1", 80'(ret_cnt), 80'(0));
`endif
      cyc();
      #4;
`ifdef BW_WB_BYPASS_EN
      chk("s_wr_n2", 80'(rf_wr), 80'(0));
`else
      chk("s_wr_n2", 80'(rf_wr), 80'(1));
      chk("s_wa_n2", 80'(rf_wa), 80'(5));
      chk("s_wd_n2", rf_wd, 80'h1234);
      chk("s_tid_n2", 80'(rf_tid), 80'(8'h15));
`endif
      chk("s_ret_n2", 80'(ret_cnt), 80'(1));
      cyc();

      // Forwarding priority under stall, then reset with three entries queued
      drive(1'b1, 80'h1, 6'd7, 1'b1, 6'd0, 6'd0);
      #4;
      cyc();
      drive(1'b1, 80'h2, 6'd7, 1'b1, 6'd0, 6'd0);
      #4;
      cyc();
      drive(1'b1, 80'h3, 6'd9, 1'b1, 6'd7, 6'd8);
      #4;
      chk("p_ha", 80'(fwd_ha), 80'(1));
      chk("p_va", fwd_va, 80'h2);
      chk("p_hb", 80'(fwd_hb), 80'(0));
      chk("p_vb", fwd_vb, 80'h0);
      cyc();
      rst = 1'b1;
      drive(1'b0, 80'h0, 6'd0, 1'b1, 6'd7, 6'd9);
      #4;
      chk("p_hb9", 80'(fwd_hb), 80'(1));
      chk("p_vb9", fwd_vb, 80'h3);
      cyc();
      rst = 1'b0;
      drive(1'b0, 80'h0, 6'd0, 1'b0, 6'd7, 6'd9);
      for (int i = 0; i < 4; i++) begin
         #4;
         chk("r_wr", 80'(rf_wr), 80'(0));
         chk("r_ret", 80'(ret_cnt), 80'(0));
         chk("r_rdy", 80'(alu_rdy), 80'(1));
         chk("r_ha", 80'(fwd_ha), 80'(0));
         chk("r_va", fwd_va, 80'h0);
         chk("r_hb", 80'(fwd_hb), 80'(0));
         chk("r_vb", fwd_vb, 80'h0);
         cyc();
      end

      // Random traffic against the reference model
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         r96 = {$urandom(), $urandom(), $urandom()};
         drive(($urandom_range(0, 3) != 0), r96[79:0], RW'($urandom_range(0, 7)),
               ($urandom_range(0, 9) < 4), RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)));
         rst = ($urandom_range(0, 299) == 0);
         #4;
         check_model();
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
